// File: rtl/result_fifo_pkg.sv
// Shared word-width and depth defaults for the result FIFO and its upstream wrapper.
package result_fifo_pkg;
  localparam int RF_DATA_W = 21;
  localparam int RF_DEPTH  = 16;
  localparam int RF_ADDR_W = $clog2(RF_DEPTH);
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one registered read port.
module fifo_mem
  import result_fifo_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/result_fifo.sv
// Synchronous result FIFO: pointer/count/flag control around a fifo_mem array.
module result_fifo
  import result_fifo_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Flags come from the current count, so a full FIFO still drains and an
  // empty FIFO never lets a same-cycle write fall through to the reader.
  assign wr_acc = wr_req && !full && !rst;
  assign rd_acc = rd_req && !empty && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rd_valid <= rd_acc;
      if (wr_req && full)  wr_err <= 1'b1;
      if (rd_req && empty) rd_err <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_result_fifo.sv
// Scoreboard bench for result_fifo: queue-based reference model, directed scenarios plus random traffic.
module tb_result_fifo;
  localparam int DATA_W = 21;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_req = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              full;
  logic              rd_req = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              wr_err;
  logic              rd_err;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_last = '0;
  logic              m_vld = 1'b0;
  logic              m_wr_err = 1'b0;
  logic              m_rd_err = 1'b0;

  result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_data  (wr_data),
    .full     (full),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .count    (count),
    .wr_err   (wr_err),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    int n;
    n = model_q.size();
    chk("count", 32'(count), 32'(n));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("wr_err", 32'(wr_err), 32'(m_wr_err));
    chk("rd_err", 32'(rd_err), 32'(m_rd_err));
    chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    chk("rd_data_hold", 32'(rd_data), 32'(m_last));
  endtask

  // One clock of stimulus; the reference model decides acceptance from its own occupancy.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    logic rd_ok, wr_ok;
    @(negedge clk);
    wr_req  = w;
    rd_req  = r;
    wr_data = d;
    @(posedge clk);
    rd_ok = r && (model_q.size() > 0);
    wr_ok = w && (model_q.size() < DEPTH);
    if (w && model_q.size() == DEPTH) m_wr_err = 1'b1;
    if (r && model_q.size() == 0)     m_rd_err = 1'b1;
    if (rd_ok) begin
      m_last = model_q.pop_front();
      exp_q.push_back(m_last);
    end
    if (wr_ok) model_q.push_back(d);
    m_vld = rd_ok;
    #1;
    chk_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    wr_data = 21'h00055;
    model_q.delete();
    m_last   = '0;
    m_vld    = 1'b0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
    #1;
    chk_state();
    @(posedge clk);
    #1;
    chk_state();
    @(negedge clk);
    rst    = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected read.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got rd_data 0x%0h with no read outstanding at %0t", rd_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL sb_data: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
          end
        end
      end
    end
  end

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);

    // Fill to full, then one overflowing write.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, DATA_W'(i));
    step(1'b1, 1'b0, 21'h00011);
    // Drain, then one underflowing read.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Steady-state simultaneous traffic at count 5, wrapping pointers.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DATA_W'(21'h00100 + i));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DATA_W'(21'h00200 + i));
    step(1'b0, 1'b0, '0);

    // Simultaneous request on empty: write wins, no fall-through.
    do_reset();
    step(1'b1, 1'b1, 21'h1ABCD);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Reset mid-burst discards stored words.
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, DATA_W'(21'h00300 + i));
    do_reset();
    step(1'b1, 1'b0, 21'h0BEEF);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Randomised traffic with phases biased toward filling and draining.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int bias;
      if (i % 400 == 399) do_reset();
      bias = ((i / 60) % 2 == 0) ? 70 : 30;
      step($urandom_range(99) < bias, $urandom_range(99) >= bias,
           DATA_W'($urandom));
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter DATA_W, default 21, SHALL set the width of each stored word; it matches the wrapper wr_data width.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of entries; it SHALL be a power of two, 2..256.
REQ-003 Derived constant ADDR_W SHALL equal log2(DEPTH).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_req  input  1  write request from the upstream wrapper, one word per cycle.
REQ-007 wr_data  input  DATA_W  word written when wr_req is accepted.
REQ-008 full  output  1  high when count equals DEPTH.
REQ-009 rd_req  input  1  read request from the downstream consumer.
REQ-010 rd_data  output  DATA_W  registered read word.
REQ-011 rd_valid  output  1  one-cycle pulse marking rd_data as new.
REQ-012 empty  output  1  high when count equals 0.
REQ-013 count  output  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-014 wr_err  output  1  sticky overflow flag.
REQ-015 rd_err  output  1  sticky underflow flag.

Function
REQ-016 A write SHALL be accepted when wr_req=1 and full=0: wr_data is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-017 A read SHALL be accepted when rd_req=1 and empty=0: the word at rd_ptr is loaded into rd_data, rd_valid=1 in the next cycle, and rd_ptr increments modulo DEPTH.
REQ-018 Read latency SHALL be exactly one cycle from the accepting edge; rd_data SHALL hold its value until the next accepted read.
REQ-019 rd_valid SHALL be 0 in every cycle not following an accepted read.
REQ-020 count SHALL be +1 on write-only, -1 on read-only, and unchanged on simultaneous accepted read and write or on no access.
REQ-021 full and empty SHALL be derived combinationally from count, with no extra cycle of delay.
REQ-022 When full=1 and wr_req=1 and rd_req=1, the read SHALL be accepted and the write rejected; wr_err SHALL set.
REQ-023 When empty=1 and wr_req=1 and rd_req=1, the write SHALL be accepted and the read rejected (no fall-through); rd_err SHALL set.
REQ-024 A rejected write SHALL leave memory, wr_ptr and count unchanged; a rejected read SHALL leave rd_data, rd_ptr and count unchanged.
REQ-025 wr_err and rd_err SHALL remain set until reset.
REQ-026 Pointer wrap-around SHALL be seamless: data order is strictly first-in, first-out across the wrap.

Reset
REQ-027 Asserting rst SHALL immediately clear the following: wr_ptr, rd_ptr, count, rd_data (0), rd_valid (0), wr_err (0) and rd_err (0).
REQ-028 After reset, empty SHALL be 1 and full SHALL be 0.
REQ-029 A reset asserted mid-burst SHALL discard all stored words; memory contents need not be cleared.
REQ-030 No access SHALL be accepted in a cycle where rst is high.

Structure
REQ-031 A shared package SHALL hold DATA_W, DEPTH and ADDR_W defaults, so that the wrapper and the FIFO agree on word width.
REQ-032 Storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_W register array with one synchronous write port and one synchronous read port, and no reset on the array.
REQ-033 Pointer, count and flag logic SHALL reside in result_fifo.

Verification
REQ-034 Reset then idle -> empty=1, full=0, count=0, rd_valid=0, wr_err=0, rd_err=0.
REQ-035 Write 16 words 0x00001..0x00010, then 1 more write -> full=1 after the 16th, count=16, wr_err=1, and the 17th word is not stored.
REQ-036 Read 16 times after the fill -> rd_data sequence 0x00001..0x00010, each a cycle after rd_req with rd_valid=1; then empty=1; a 17th read sets rd_err=1 with rd_data held at 0x00010.
REQ-037 At count=5, hold wr_req and rd_req for 20 cycles -> count stays 5, pointers wrap, and output order is preserved with no error flags.
REQ-038 Simultaneous wr_req and rd_req when empty, with data 0x1ABCD -> count=1, rd_valid=0, rd_err=1; the next read returns 0x1ABCD.
REQ-039 Assert rst while count=9 -> count=0, empty=1, and the flags clear at once; the first post-reset write/read returns the new data only.
